// File: rtl/multi_alarm_clock.sv
// 24-hour HH:MM clock with NUM_ALARMS armed alarms, validated keypad entry, snooze and
// auto-off ringing. Time, alarms and the entry shadow are held as BCD digits {H1,H0,M1,M0}.
module multi_alarm_clock #(
    parameter int unsigned NUM_ALARMS         = 4,
    parameter int unsigned TICKS_PER_MIN      = 256,
    parameter int unsigned FAST_TICKS_PER_MIN = 4,
    parameter int unsigned SNOOZE_MIN         = 5,
    parameter int unsigned RING_MIN           = 2,
    localparam int unsigned IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            key,
    input  logic                  key_valid,
    input  logic                  time_button,
    input  logic                  alarm_button,
    input  logic [IDX_W-1:0]      alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_enable,
    input  logic                  fastwatch,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [7:0]            ms_hour,
    output logic [7:0]            ls_hour,
    output logic [7:0]            ms_minute,
    output logic [7:0]            ls_minute,
    output logic                  alarm_sound,
    output logic [IDX_W-1:0]      alarm_active,
    output logic                  entry_busy
);

    localparam int unsigned TickW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int unsigned RingW = (RING_MIN > 1) ? $clog2(RING_MIN) : 1;
    localparam int unsigned SnzW  = (SNOOZE_MIN > 1) ? $clog2(SNOOZE_MIN) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_MIN - 1);
    localparam logic [TickW-1:0] FastLast = TickW'(FAST_TICKS_PER_MIN - 1);
    localparam logic [RingW-1:0] RingLast = RingW'(RING_MIN - 1);
    localparam logic [SnzW-1:0]  SnzLast  = SnzW'(SNOOZE_MIN - 1);

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    typedef enum logic [2:0] {StIdle, StH1, StH0, StM1, StM0, StCommit} entry_e;
    typedef enum logic [1:0] {StOff, StRing, StSnooze} ring_e;

    logic [TickW-1:0] tick_q, tick_d;
    hhmm_t            time_q, time_d;
    hhmm_t            alarm_q [NUM_ALARMS];
    hhmm_t            alarm_d [NUM_ALARMS];
    hhmm_t            shadow_q, shadow_d;
    hhmm_t            sel_alarm;
    hhmm_t            disp;
    logic             tbtn_q, abtn_q;
    entry_e           entry_q, entry_d;
    logic             tgt_alarm_q, tgt_alarm_d;
    logic [IDX_W-1:0] tgt_idx_q, tgt_idx_d;
    logic             chk_q, chk_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    ring_e            ring_q, ring_d;
    logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SnzW-1:0]  snz_cnt_q, snz_cnt_d;
    logic [IDX_W-1:0] active_q, active_d;

    logic tbtn_rise, abtn_rise, wrap, commit_time, commit_alarm, min_pulse;

    function automatic hhmm_t inc_minute(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.m0 != 4'd9) begin
            r.m0 = t.m0 + 4'd1;
        end else begin
            r.m0 = 4'd0;
            if (t.m1 != 4'd5) begin
                r.m1 = t.m1 + 4'd1;
            end else begin
                r.m1 = 4'd0;
                if (t.h1 == 4'd2 && t.h0 == 4'd3) begin
                    r.h1 = 4'd0;
                    r.h0 = 4'd0;
                end else if (t.h0 == 4'd9) begin
                    r.h0 = 4'd0;
                    r.h1 = t.h1 + 4'd1;
                end else begin
                    r.h0 = t.h0 + 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign tbtn_rise    = time_button & ~tbtn_q;
    assign abtn_rise    = alarm_button & ~abtn_q;
    assign commit_time  = (entry_q == StCommit) && !tgt_alarm_q;
    assign commit_alarm = (entry_q == StCommit) && tgt_alarm_q;
    // >= rather than == so a switch to fastwatch mid-count wraps on the next cycle
    assign wrap         = tick_q >= (fastwatch ? FastLast : TickLast);
    assign min_pulse    = wrap && !commit_time;

    always_comb begin
        tick_d = (wrap || commit_time) ? '0 : tick_q + 1'b1;
        time_d = time_q;
        if (commit_time) begin
            time_d = shadow_q;
        end else if (min_pulse) begin
            time_d = inc_minute(time_q);
        end
        chk_d = min_pulse || commit_time;
    end

    always_comb begin
        sel_alarm = '0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            alarm_d[i] = alarm_q[i];
            if (alarm_sel == IDX_W'(i)) begin
                sel_alarm = alarm_q[i];
            end
            if (commit_alarm && tgt_idx_q == IDX_W'(i)) begin
                alarm_d[i] = shadow_q;
            end
        end
    end

    // Entry FSM: one digit per accepted key, out-of-range keys hold the state
    always_comb begin
        entry_d     = entry_q;
        shadow_d    = shadow_q;
        tgt_alarm_d = tgt_alarm_q;
        tgt_idx_d   = tgt_idx_q;
        unique case (entry_q)
            StIdle: begin
                if (tbtn_rise) begin
                    shadow_d    = time_q;
                    tgt_alarm_d = 1'b0;
                    entry_d     = StH1;
                end else if (abtn_rise) begin
                    shadow_d    = sel_alarm;
                    tgt_alarm_d = 1'b1;
                    tgt_idx_d   = alarm_sel;
                    entry_d     = StH1;
                end
            end
            StH1: begin
                if (key_valid && key <= 4'd2) begin
                    shadow_d.h1 = key;
                    if (key == 4'd2 && shadow_q.h0 > 4'd3) begin
                        shadow_d.h0 = 4'd0;
                    end
                    entry_d = StH0;
                end
            end
            StH0: begin
                if (key_valid && key <= ((shadow_q.h1 == 4'd2) ? 4'd3 : 4'd9)) begin
                    shadow_d.h0 = key;
                    entry_d     = StM1;
                end
            end
            StM1: begin
                if (key_valid && key <= 4'd5) begin
                    shadow_d.m1 = key;
                    entry_d     = StM0;
                end
            end
            StM0: begin
                if (key_valid && key <= 4'd9) begin
                    shadow_d.m0 = key;
                    entry_d     = StCommit;
                end
            end
            StCommit: entry_d = StIdle;
            default:  entry_d = StIdle;
        endcase
    end

    // Match stage; the descending scan leaves the lowest matching slot as the winner
    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = '0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (chk_q && alarm_enable[i] && (alarm_q[i] == time_q)) begin
                hit_d     = 1'b1;
                hit_idx_d = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        active_d   = active_q;
        unique case (ring_q)
            StOff: begin
                if (hit_q) begin
                    ring_d     = StRing;
                    ring_cnt_d = '0;
                    active_d   = hit_idx_q;
                end
            end
            StRing: begin
                if (stop) begin
                    ring_d = StOff;
                end else if (snooze) begin
                    ring_d    = StSnooze;
                    snz_cnt_d = '0;
                end else if (min_pulse) begin
                    if (ring_cnt_q == RingLast) begin
                        ring_d = StOff;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                    end
                end
            end
            StSnooze: begin
                if (stop) begin
                    ring_d = StOff;
                end else if (min_pulse) begin
                    if (snz_cnt_q == SnzLast) begin
                        ring_d     = StRing;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
                end
            end
            default: ring_d = StOff;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q      <= '0;
            time_q      <= '0;
            alarm_q     <= '{default: '0};
            shadow_q    <= '0;
            tbtn_q      <= 1'b0;
            abtn_q      <= 1'b0;
            entry_q     <= StIdle;
            tgt_alarm_q <= 1'b0;
            tgt_idx_q   <= '0;
            chk_q       <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            ring_q      <= StOff;
            ring_cnt_q  <= '0;
            snz_cnt_q   <= '0;
            active_q    <= '0;
        end else begin
            tick_q      <= tick_d;
            time_q      <= time_d;
            alarm_q     <= alarm_d;
            shadow_q    <= shadow_d;
            tbtn_q      <= time_button;
            abtn_q      <= alarm_button;
            entry_q     <= entry_d;
            tgt_alarm_q <= tgt_alarm_d;
            tgt_idx_q   <= tgt_idx_d;
            chk_q       <= chk_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            active_q    <= active_d;
        end
    end

    assign entry_busy   = (entry_q != StIdle);
    assign disp         = entry_busy ? shadow_q : time_q;
    assign ms_hour      = 8'h30 + {4'h0, disp.h1};
    assign ls_hour      = 8'h30 + {4'h0, disp.h0};
    assign ms_minute    = 8'h30 + {4'h0, disp.m1};
    assign ls_minute    = 8'h30 + {4'h0, disp.m0};
    assign alarm_sound  = (ring_q == StRing);
    assign alarm_active = active_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed and random bench for multi_alarm_clock against a minute-count reference model.
module tb_multi_alarm_clock;

    localparam int NA   = 4;
    localparam int TPM  = 256;
    localparam int FTPM = 4;
    localparam int SNZ  = 5;
    localparam int RNG  = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       key_valid, time_button, alarm_button, fastwatch, snooze, stop;
    logic [1:0] alarm_sel;
    logic [3:0] alarm_enable;
    logic [7:0] ms_hour, ls_hour, ms_minute, ls_minute;
    logic       alarm_sound, entry_busy;
    logic [1:0] alarm_active;

    int errors = 0;
    int checks = 0;

    // Reference model: time and alarms as minutes since midnight
    int m_time, m_tick, m_pos, m_tgt, m_ring, m_rpulses, m_spulses, m_active;
    int m_alarm [NA];
    int m_sh [4];
    bit m_tb_prev, m_ab_prev, m_chk, m_hit;
    int m_hit_idx;

    multi_alarm_clock #(
        .NUM_ALARMS(NA), .TICKS_PER_MIN(TPM), .FAST_TICKS_PER_MIN(FTPM),
        .SNOOZE_MIN(SNZ), .RING_MIN(RNG)
    ) dut (
        .clock(clock), .reset(reset), .key(key), .key_valid(key_valid),
        .time_button(time_button), .alarm_button(alarm_button), .alarm_sel(alarm_sel),
        .alarm_enable(alarm_enable), .fastwatch(fastwatch), .snooze(snooze), .stop(stop),
        .ms_hour(ms_hour), .ls_hour(ls_hour), .ms_minute(ms_minute), .ls_minute(ls_minute),
        .alarm_sound(alarm_sound), .alarm_active(alarm_active), .entry_busy(entry_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_time = 0; m_tick = 0; m_pos = -1; m_tgt = -1;
        m_ring = 0; m_rpulses = 0; m_spulses = 0; m_active = 0;
        m_tb_prev = 0; m_ab_prev = 0; m_chk = 0; m_hit = 0; m_hit_idx = 0;
        for (int i = 0; i < NA; i++) m_alarm[i] = 0;
        for (int i = 0; i < 4; i++) m_sh[i] = 0;
    endtask

    function automatic int dig(input int k);
        int h, m;
        if (m_pos >= 0) return m_sh[k];
        h = m_time / 60;
        m = m_time % 60;
        case (k)
            0: return h / 10;
            1: return h % 10;
            2: return m / 10;
            default: return m % 10;
        endcase
    endfunction

    function automatic int max_digit(input int pos);
        case (pos)
            0: return 2;
            1: return (m_sh[0] == 2) ? 3 : 9;
            2: return 5;
            default: return 9;
        endcase
    endfunction

    task automatic load_shadow(input int t);
        m_sh[0] = (t / 60) / 10;
        m_sh[1] = (t / 60) % 10;
        m_sh[2] = (t % 60) / 10;
        m_sh[3] = (t % 60) % 10;
    endtask

    function automatic int shadow_min();
        return (m_sh[0] * 10 + m_sh[1]) * 60 + m_sh[2] * 10 + m_sh[3];
    endfunction

    task automatic model_step();
        int  old_time;
        bit  wrap, commit_t, minp;
        old_time = m_time;
        wrap     = m_tick >= (fastwatch ? FTPM : TPM) - 1;
        commit_t = (m_pos == 4) && (m_tgt < 0);
        minp     = wrap && !commit_t;
        case (m_ring)
            0: if (m_hit) begin m_ring = 1; m_active = m_hit_idx; m_rpulses = 0; end
            1: begin
                if (stop) m_ring = 0;
                else if (snooze) begin m_ring = 2; m_spulses = 0; end
                else if (minp) begin
                    m_rpulses++;
                    if (m_rpulses == RNG) m_ring = 0;
                end
            end
            default: begin
                if (stop) m_ring = 0;
                else if (minp) begin
                    m_spulses++;
                    if (m_spulses == SNZ) begin m_ring = 1; m_rpulses = 0; end
                end
            end
        endcase
        m_hit = 0;
        if (m_chk) begin
            for (int i = 0; i < NA; i++) begin
                if (!m_hit && alarm_enable[i] && m_alarm[i] == m_time) begin
                    m_hit = 1;
                    m_hit_idx = i;
                end
            end
        end
        m_chk = minp || commit_t;
        if (commit_t) m_time = shadow_min();
        else if (minp) m_time = (m_time + 1) % 1440;
        if (m_pos == 4 && m_tgt >= 0) m_alarm[m_tgt] = shadow_min();
        m_tick = (wrap || commit_t) ? 0 : m_tick + 1;
        if (m_pos < 0) begin
            if (time_button && !m_tb_prev) begin
                load_shadow(old_time); m_tgt = -1; m_pos = 0;
            end else if (alarm_button && !m_ab_prev) begin
                load_shadow(m_alarm[alarm_sel]); m_tgt = int'(alarm_sel); m_pos = 0;
            end
        end else if (m_pos == 4) begin
            m_pos = -1;
        end else if (key_valid && int'(key) <= max_digit(m_pos)) begin
            if (m_pos == 0 && key == 4'd2 && m_sh[1] > 3) m_sh[1] = 0;
            m_sh[m_pos] = int'(key);
            m_pos++;
        end
        m_tb_prev = time_button;
        m_ab_prev = alarm_button;
    endtask

    task automatic compare_all();
        check("ms_hour", ms_hour, 8'h30 + 8'(dig(0)));
        check("ls_hour", ls_hour, 8'h30 + 8'(dig(1)));
        check("ms_minute", ms_minute, 8'h30 + 8'(dig(2)));
        check("ls_minute", ls_minute, 8'h30 + 8'(dig(3)));
        check("alarm_sound", {7'b0, alarm_sound}, 8'(m_ring == 1));
        check("alarm_active", {6'b0, alarm_active}, 8'(m_active));
        check("entry_busy", {7'b0, entry_busy}, 8'(m_pos >= 0));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
        key_valid = 1'b0;
        snooze    = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_disp(input string tag, input string s);
        check({tag, "_h1"}, ms_hour, s[0]);
        check({tag, "_h0"}, ls_hour, s[1]);
        check({tag, "_m1"}, ms_minute, s[2]);
        check({tag, "_m0"}, ls_minute, s[3]);
    endtask

    task automatic check_reset_vals(input string tag);
        check_disp(tag, "0000");
        check({tag, "_sound"}, {7'b0, alarm_sound}, 8'h00);
        check({tag, "_active"}, {6'b0, alarm_active}, 8'h00);
        check({tag, "_busy"}, {7'b0, entry_busy}, 8'h00);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        time_button = 1'b0;
        alarm_button = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        compare_all();
    endtask

    task automatic press_time();
        time_button = 1'b1; tick();
        time_button = 1'b0; tick();
    endtask

    task automatic press_alarm(input logic [1:0] sel);
        alarm_sel = sel; alarm_button = 1'b1; tick();
        alarm_button = 1'b0; tick();
    endtask

    task automatic key_in(input logic [3:0] d);
        key = d; key_valid = 1'b1; tick();
        tick();
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d);
        key_in(a); key_in(b); key_in(c); key_in(d);
    endtask

    task automatic wait_sound(input string tag, input logic level, input int budget);
        int n;
        n = 0;
        while (alarm_sound !== level && n < budget) begin
            tick();
            n++;
        end
        check(tag, {7'b0, alarm_sound}, {7'b0, level});
    endtask

    initial begin
        reset = 1'b0; key = 4'd0; key_valid = 1'b0; time_button = 1'b0;
        alarm_button = 1'b0; alarm_sel = 2'd0; alarm_enable = 4'b0; fastwatch = 1'b0;
        snooze = 1'b0; stop = 1'b0;
        model_reset();
        #1;
        check_reset_vals("por");
        @(negedge clock);
        reset = 1'b1;
        ticks(3);

        // Time entry then one fast minute
        press_time();
        enter4(1, 2, 3, 4);
        check_disp("set1234", "1234");
        fastwatch = 1'b1;
        ticks(4);
        check_disp("fast1235", "1235");
        fastwatch = 1'b0;

        // Validation: 7 rejected at H0, then 23:59 rolls to 00:00
        press_time();
        key_in(2); key_in(7);
        check("h0_pending_busy", {7'b0, entry_busy}, 8'h01);
        key_in(3); key_in(5); key_in(9);
        check_disp("set2359", "2359");
        fastwatch = 1'b1;
        ticks(4);
        check_disp("roll0000", "0000");
        fastwatch = 1'b0;

        // H1=2 clears a shadow H0 above 3
        press_time();
        enter4(1, 9, 0, 5);
        press_time();
        key_in(2);
        check("h0_cleared", ls_hour, "0");
        key_in(1); key_in(0); key_in(0);
        check_disp("set2100", "2100");

        // Alarm slot 2 at 12:35
        press_alarm(2);
        enter4(1, 2, 3, 5);
        alarm_enable = 4'b0100;
        press_time();
        enter4(1, 2, 3, 4);
        fastwatch = 1'b1;
        ticks(4);
        check_disp("disp1235", "1235");
        check("sound_pre", {7'b0, alarm_sound}, 8'h00);
        ticks(2);
        check("sound_ring", {7'b0, alarm_sound}, 8'h01);
        check("active2", {6'b0, alarm_active}, 8'h02);

        // Snooze, re-ring, then stop+snooze together
        snooze = 1'b1; tick();
        check("sound_snooze", {7'b0, alarm_sound}, 8'h00);
        wait_sound("resnooze_ring", 1'b1, 40);
        stop = 1'b1; snooze = 1'b1; tick();
        check("stop_wins", {7'b0, alarm_sound}, 8'h00);
        ticks(30);

        // Slot 0 also matching wins; unacknowledged ring auto-offs
        fastwatch = 1'b0;
        press_alarm(0);
        enter4(1, 2, 3, 5);
        alarm_enable = 4'b0101;
        press_time();
        enter4(1, 2, 3, 4);
        fastwatch = 1'b1;
        wait_sound("ring_slot0", 1'b1, 20);
        check("active0", {6'b0, alarm_active}, 8'h00);
        wait_sound("auto_off", 1'b0, 20);

        // Reset mid-ring and mid-entry
        fastwatch = 1'b0;
        press_time();
        enter4(1, 2, 3, 4);
        fastwatch = 1'b1;
        wait_sound("ring_again", 1'b1, 20);
        apply_reset("rst_ring");
        fastwatch = 1'b0;
        ticks(5);
        press_time();
        key_in(1);
        apply_reset("rst_entry");
        ticks(20);

        // Both buttons together; commit coincident with a minute wrap
        time_button = 1'b1; alarm_button = 1'b1; tick();
        time_button = 1'b0; alarm_button = 1'b0; tick();
        key_in(0); key_in(7); key_in(4);
        key = 4'd5; key_valid = 1'b1; tick();
        fastwatch = 1'b1;
        tick();
        check_disp("commit0745", "0745");
        fastwatch = 1'b0;

        // fastwatch raised mid-count
        ticks(10);
        fastwatch = 1'b1;
        ticks(3);
        fastwatch = 1'b0;

        // Random stimulus
        for (int n = 0; n < 3000; n++) begin
            key       = 4'($urandom_range(0, 15));
            key_valid = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 39) == 0) time_button = ~time_button;
            if ($urandom_range(0, 39) == 0) alarm_button = ~alarm_button;
            alarm_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) alarm_enable = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) fastwatch = ~fastwatch;
            snooze = ($urandom_range(0, 29) == 0);
            stop   = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised successor to the single-alarm clock top: a 24-hour HH:MM clock with NUM_ALARMS independently enabled alarms, validated digit-by-digit keypad entry, snooze and auto-off ringing. It drives four ASCII digit outputs and a sounder line, and sits between the keypad/button front end and the display driver.

## Interface
- NUM_ALARMS, 4: alarm slots, 1..16; IDX_W = max(1, clog2(NUM_ALARMS)) is derived.
- TICKS_PER_MIN, 256: clock cycles per minute in normal mode.
- FAST_TICKS_PER_MIN, 4: clock cycles per minute while fastwatch=1; must be ≤ TICKS_PER_MIN.
- SNOOZE_MIN, 5: snooze length in minutes, ≥1.
- RING_MIN, 2: minutes of unacknowledged ringing before auto-off, ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key  in  4  digit value 0-9; values 10-15 are invalid.
- key_valid  in  1  one-cycle strobe qualifying key.
- time_button  in  1  level; rising edge starts time entry.
- alarm_button  in  1  level; rising edge starts alarm entry for slot alarm_sel.
- alarm_sel  in  IDX_W  alarm slot to edit; sampled on the alarm_button edge.
- alarm_enable  in  NUM_ALARMS  per-slot arm bits, level.
- fastwatch  in  1  selects FAST_TICKS_PER_MIN.
- snooze  in  1  one-cycle pulse.
- stop  in  1  one-cycle pulse.
- ms_hour, ls_hour, ms_minute, ls_minute  out  8 each  ASCII digit (8'h30 + value).
- alarm_sound  out  1  high while ringing.
- alarm_active  out  IDX_W  slot that caused the current ring or snooze.
- entry_busy  out  1  high while the entry FSM is outside IDLE.

## Operation
- Tick counter: increments every cycle. When count ≥ limit−1 (limit depends on fastwatch), it wraps to 0 and raises min_pulse. The ≥ compare makes a mid-count switch to fastwatch wrap on the next cycle.
- Time: on min_pulse, add one minute. Wraps 59→00 minutes with hour carry, and 23:59→00:00.
- Entry FSM states: IDLE → H1 → H0 → M1 → M0 → COMMIT → IDLE.
  - On a button rising edge in IDLE, the shadow register loads the target value: current time, or alarm[alarm_sel]. time_button wins if both buttons rise together.
  - Each valid key_valid writes one digit and advances the state.
  - Digit limits: H1 0-2; H0 0-9, or 0-3 when H1=2; M1 0-5; M0 0-9. An out-of-range key is ignored and the state is held.
  - If H1 is entered as 2 while the shadow H0 > 3, shadow H0 is cleared to 0.
  - COMMIT (one cycle) writes the shadow to the target. A time commit also clears the tick counter; a min_pulse in the same cycle is discarded.
  - Button edges outside IDLE are ignored.
- Display: shows the shadow register while entry_busy=1 (time or alarm entry), otherwise the current time.
- Match check: runs in the cycle after a min_pulse time update or a time commit; alarm commits do not trigger it. A slot matches when its enable bit is set and alarm == time. The lowest matching index wins.
- Ring FSM states: OFF, RING, SNZ.
  - OFF → RING on match; alarm_active latches the winning index.
  - RING: stop → OFF; snooze → SNZ; RING_MIN minute pulses → OFF.
  - SNZ: SNOOZE_MIN minute pulses → RING, with the ring-minute count reset; stop → OFF.
  - stop wins over snooze in the same cycle. Matches are ignored outside OFF.
  - Clearing alarm_enable for the active slot does not silence the ring; only stop or auto-off does.

## Timing
- Reset: time 00:00, all alarms 00:00, tick counter 0, FSMs in IDLE/OFF. Outputs: all digits 8'h30, alarm_sound 0, alarm_active 0, entry_busy 0.
- A button edge is detected from a one-cycle delayed copy; entry_busy rises on the clock after the edge.
- A digit is stored on the edge that samples key_valid. COMMIT follows the M0 digit by one cycle, and the new value is displayed the cycle after COMMIT.
- The time digits change on the clock edge where the counter wraps. alarm_sound rises two edges after that update: one edge for the check, one for the FSM.
- stop/snooze drop alarm_sound on the next edge.

## Test plan
- Reset mid-ring and mid-entry: assert reset → all outputs at reset values immediately, no clock needed.
- Time entry: time_button rise, then keys 1,2,3,4 → display "12:34"; then FAST=1 with fastwatch and wait 4 cycles → "12:35".
- Validation: keys 2,7 → 7 ignored, H0 still pending; then 3,5,9 → 23:59; after one min_pulse → 00:00.
- Alarm match: slot 2 = 12:35 enabled, time 12:34, fastwatch → alarm_sound=1 with alarm_active=2 two cycles after display reaches 12:35. Slot 0 = 12:35 also enabled → alarm_active=0.
- Snooze/stop: snooze while ringing → sound 0, back to 1 after 5 minute pulses; stop together with snooze → OFF; no acknowledgement → OFF after 2 minute pulses.
- Collisions: both buttons rising together → time entry; fastwatch toggled mid-count → next wrap at ≤ limit; time commit coincident with min_pulse → committed value kept exactly.
